hazard_scoreboard: RTL and testbench

- Parametrised RAW/WAW/write-port hazard unit that replaces the constant-zero pipeline stall with a real, latency-aware one.
- Sits between decode and execute.
- Keeps a per-register countdown of cycles until a pending result can be forwarded, plus a writeback-slot occupancy ring.
- Holds the decode→execute handoff until all operands are forwardable and the destination's writeback slot is free; supports variable-latency units (ALU, load, multi-cycle FPU).

---
 rtl/hazard_scoreboard_pkg.sv | 24 ++
 rtl/sb_wb_ring.sv | 52 +++++
 rtl/hazard_scoreboard.sv | 124 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the decode/execute hazard scoreboard: unit latencies,
// the hard-wired zero register address and the latency clamp helper.
package hazard_scoreboard_pkg;

  localparam int LAT_ALU       = 1;
  localparam int LAT_LOAD      = 2;
  localparam int LAT_FMUL      = 4;
  localparam int LAT_FDIV      = 7;
  localparam int ZERO_REG_ADDR = 0;

  // Out-of-range latencies are forced into [1, max_lat] so the unit never deadlocks.
  function automatic int clamp_lat(input int lat, input int max_lat);
    int res;
    if (lat < 1) begin
      res = 1;
    end else if (lat > max_lat) begin
      res = max_lat;
    end else begin
      res = lat;
    end
    return res;
  endfunction

endpackage

// File: rtl/sb_wb_ring.sv
// Writeback-slot occupancy ring: bit k set means a result lands k cycles after
// the current one. Shifts toward index 0 every unfrozen cycle.
module sb_wb_ring #(
  parameter int DEPTH = 7,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [IDX_W-1:0] query_idx,
  output logic             occ,
  output logic             any_next
);

  logic [DEPTH-1:0] ring_r;
  logic [DEPTH-1:0] shift_s;
  logic [DEPTH-1:0] ring_nxt_s;

  assign shift_s = {1'b0, ring_r[DEPTH-1:1]};

  // Queries look at the post-shift ring, the same frame a new entry is set in.
  assign occ = (int'(query_idx) < DEPTH) ? shift_s[query_idx] : 1'b0;

  assign any_next = |ring_nxt_s;

  // Next ring: frozen on hold, otherwise shift then mark the new slot.
  always_comb begin
    ring_nxt_s = ring_r;
    if (hold) begin
      ring_nxt_s = ring_r;
    end else begin
      ring_nxt_s = shift_s;
      if (set_en && (int'(set_idx) < DEPTH)) begin
        ring_nxt_s[set_idx] = 1'b1;
      end else begin
        ring_nxt_s = shift_s;
      end
    end
  end

  // Ring state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ring_r <= {DEPTH{1'b0}};
    end else begin
      ring_r <= ring_nxt_s;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Latency-aware RAW/WAW/writeback-port hazard unit between decode and execute.
// Per-register countdowns say how many cycles remain until a result forwards.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 64,
  parameter int ADDR_W   = 6,
  parameter int MAX_LAT  = 7,
  parameter int CNT_W    = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic              issue_rs1_used,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic              issue_rs2_used,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_rd_we,
  input  logic [CNT_W-1:0]  issue_lat,
  output logic              stall,
  output logic              issue_fire,
  output logic              pending_any,
  output logic              lat_err
);

  localparam bit                ZERO_EN   = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_ADDR);

  logic [CNT_W-1:0] cnt_r     [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt_s [NUM_REGS];
  logic             cnt_any_s;
  logic             ring_any_s;
  logic             slot_busy_s;
  logic [CNT_W-1:0] eff_lat_s;
  logic [CNT_W-1:0] lat_m1_s;
  logic             lat_bad_s;
  logic             rs1_chk_s, rs2_chk_s, rd_trk_s;
  logic             raw_s, waw_s, port_s;
  logic             stall_s, issue_fire_s, load_s;
  logic             pending_any_r, lat_err_r;

  // Latency decode and operand/destination hazard terms against the countdowns.
  always_comb begin
    lat_bad_s = (issue_lat == {CNT_W{1'b0}}) || (int'(issue_lat) > MAX_LAT);
    eff_lat_s = CNT_W'(clamp_lat(int'(issue_lat), MAX_LAT));
    lat_m1_s  = eff_lat_s - CNT_W'(1);
    rs1_chk_s = issue_rs1_used && !(ZERO_EN && (issue_rs1 == ZERO_ADDR));
    rs2_chk_s = issue_rs2_used && !(ZERO_EN && (issue_rs2 == ZERO_ADDR));
    rd_trk_s  = issue_rd_we && !(ZERO_EN && (issue_rd == ZERO_ADDR));
    raw_s     = (rs1_chk_s && (cnt_r[issue_rs1] != {CNT_W{1'b0}})) ||
                (rs2_chk_s && (cnt_r[issue_rs2] != {CNT_W{1'b0}}));
    waw_s     = rd_trk_s && (cnt_r[issue_rd] > lat_m1_s);
  end

  assign port_s       = rd_trk_s && slot_busy_s;
  assign stall_s      = reset && issue_valid && !flush && (raw_s || waw_s || port_s);
  assign issue_fire_s = reset && issue_valid && !flush && !hold && !stall_s;
  assign load_s       = issue_fire_s && rd_trk_s;

  assign stall       = stall_s;
  assign issue_fire  = issue_fire_s;
  assign pending_any = pending_any_r;
  assign lat_err     = lat_err_r;

  sb_wb_ring #(
    .DEPTH (MAX_LAT),
    .IDX_W (CNT_W)
  ) u_wb_ring (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .set_en    (load_s),
    .set_idx   (lat_m1_s),
    .query_idx (lat_m1_s),
    .occ       (slot_busy_s),
    .any_next  (ring_any_s)
  );

  // Countdown next state: a fire load beats the decrement of the same register.
  always_comb begin
    cnt_any_s = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (hold) begin
        cnt_nxt_s[r] = cnt_r[r];
      end else if (load_s && (issue_rd == ADDR_W'(r))) begin
        cnt_nxt_s[r] = lat_m1_s;
      end else if (cnt_r[r] != {CNT_W{1'b0}}) begin
        cnt_nxt_s[r] = cnt_r[r] - CNT_W'(1);
      end else begin
        cnt_nxt_s[r] = cnt_r[r];
      end
      cnt_any_s = cnt_any_s | (cnt_nxt_s[r] != {CNT_W{1'b0}});
    end
  end

  // Countdown array register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
      end
    end
  end

  // Status flags: occupancy summary of the next state and sticky latency error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_any_r <= 1'b0;
      lat_err_r     <= 1'b0;
    end else begin
      pending_any_r <= cnt_any_s | ring_any_s;
      lat_err_r     <= lat_err_r | (issue_valid & ~hold & lat_bad_s);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a model
// that tracks absolute ready/writeback times instead of countdowns.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NR = 64;
  localparam int AW = 6;
  localparam int ML = 7;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset, hold, flush, issue_valid;
  logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
  logic          issue_rs1_used, issue_rs2_used, issue_rd_we;
  logic [CW-1:0] issue_lat;
  logic          stall, issue_fire, pending_any, lat_err;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .MAX_LAT(ML), .CNT_W(CW), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_lat(issue_lat),
    .stall(stall), .issue_fire(issue_fire), .pending_any(pending_any), .lat_err(lat_err)
  );

  int checks = 0;
  int errors = 0;

  // Model: ready_at[r] = tick at which r becomes forwardable; wb_busy = ticks with a writeback.
  int ready_at [NR];
  bit wb_busy [int];
  int now = 0;
  int max_wb = -1;
  bit lat_err_m = 1'b0;

  function automatic int m_lat(input logic [CW-1:0] l);
    if (l == 3'd0) return 1;
    if (int'(l) > ML) return ML;
    return int'(l);
  endfunction

  function automatic bit m_stall();
    int l;
    bit s;
    if (!reset || !issue_valid || flush) return 1'b0;
    l = m_lat(issue_lat);
    s = 1'b0;
    if (issue_rs1_used && issue_rs1 != 6'd0 && ready_at[issue_rs1] > now) s = 1'b1;
    if (issue_rs2_used && issue_rs2 != 6'd0 && ready_at[issue_rs2] > now) s = 1'b1;
    if (issue_rd_we && issue_rd != 6'd0) begin
      if (ready_at[issue_rd] >= now + l) s = 1'b1;
      if (wb_busy.exists(now + l)) s = 1'b1;
    end
    return s;
  endfunction

  function automatic bit m_fire();
    return reset && issue_valid && !flush && !hold && !m_stall();
  endfunction

  function automatic bit m_pending();
    return max_wb >= now;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) ready_at[r] = 0;
    wb_busy.delete();
    max_wb = -1;
    lat_err_m = 1'b0;
  endtask

  task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit we, input int lat, input bit h, input bit f);
    issue_valid = v;  issue_rs1 = AW'(r1); issue_rs1_used = u1;
    issue_rs2 = AW'(r2); issue_rs2_used = u2;
    issue_rd = AW'(rd); issue_rd_we = we; issue_lat = CW'(lat);
    hold = h; flush = f;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0);
  endtask

  // Advance one clock and the model with the inputs currently applied.
  task automatic tick();
    bit f, bad, trk;
    int l, rd;
    f   = m_fire();
    l   = m_lat(issue_lat);
    rd  = int'(issue_rd);
    trk = issue_rd_we && issue_rd != 6'd0;
    bad = issue_valid && (issue_lat == 3'd0 || int'(issue_lat) > ML);
    @(posedge clk);
    if (reset && !hold) begin
      if (bad) lat_err_m = 1'b1;
      if (f && trk) begin
        ready_at[rd] = now + l;
        wb_busy[now + l] = 1'b1;
        if (now + l > max_wb) max_wb = now + l;
      end
      now++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1, 1'b0, 1'b0);
    model_reset();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL reset_fire got=%b exp=0", issue_fire); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", pending_any); end
    checks++; if (lat_err !== 1'b0) begin errors++; $display("FAIL reset_laterr got=%b exp=0", lat_err); end
    idle();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_alu_chain();
    drive(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, LAT_ALU, 1'b0, 1'b0);
    #1;
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL alu_prod_fire got=%b exp=1", issue_fire); end
    tick();
    checks++; if (pending_any !== 1'b1) begin errors++; $display("FAIL alu_pending got=%b exp=1", pending_any); end
    drive(1'b1, 3, 1'b1, 0, 1'b0, 4, 1'b1, LAT_ALU, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_cons_stall got=%b exp=0", stall); end
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL alu_cons_fire got=%b exp=1", issue_fire); end
    tick();
    idle();
    repeat (3) tick();
  endtask

  // Producer, idle gap, then consumer retried until it fires; stall cycles counted.
  task automatic test_hazard_stalls();
    int p_rd[3]   = '{5, 40, 20};
    int p_lat[3]  = '{LAT_LOAD, LAT_FDIV, LAT_FMUL};
    int gap[3]    = '{0, 2, 1};
    int c_rs[3]   = '{5, 1, 1};
    int c_rd[3]   = '{6, 40, 21};
    int c_lat[3]  = '{LAT_ALU, LAT_ALU, LAT_LOAD};
    int exp_st[3] = '{1, 4, 1};
    int n;
    bit fired;
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 0, 1'b0, 0, 1'b0, p_rd[s], 1'b1, p_lat[s], 1'b0, 1'b0);
      #1;
      checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL hz%0d_prod_fire got=%b exp=1", s, issue_fire); end
      tick();
      idle();
      repeat (gap[s]) tick();
      drive(1'b1, c_rs[s], 1'b1, 0, 1'b0, c_rd[s], 1'b1, c_lat[s], 1'b0, 1'b0);
      n = 0;
      fired = 1'b0;
      for (int c = 0; c < 20 && !fired; c++) begin
        #1;
        checks++; if (stall !== m_stall()) begin errors++; $display("FAIL hz%0d_stall cyc=%0d got=%b exp=%b", s, c, stall, m_stall()); end
        checks++; if (issue_fire !== m_fire()) begin errors++; $display("FAIL hz%0d_fire cyc=%0d got=%b exp=%b", s, c, issue_fire, m_fire()); end
        if (issue_fire === 1'b1) fired = 1'b1;
        else n++;
        tick();
      end
      checks++; if (!fired || n != exp_st[s]) begin errors++; $display("FAIL hz%0d_stall_cycles got=%0d fired=%b exp=%0d", s, n, fired, exp_st[s]); end
      idle();
      repeat (8) tick();
      checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL hz%0d_drained got=%b exp=0", s, pending_any); end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, LAT_LOAD, 1'b0, 1'b0);
    #1;
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL hold_prod_fire got=%b exp=1", issue_fire); end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, LAT_ALU, 1'b1, 1'b0);
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall cyc=%0d got=%b exp=1", c, stall); end
      checks++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL hold_fire cyc=%0d got=%b exp=0", c, issue_fire); end
      tick();
      checks++; if (pending_any !== 1'b1) begin errors++; $display("FAIL hold_pending cyc=%0d got=%b exp=1", c, pending_any); end
    end
    hold = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_after_stall got=%b exp=1", stall); end
    tick();
    #1;
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL hold_after_fire got=%b exp=1", issue_fire); end
    tick();
    idle();
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_and_lat();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 40, 1'b1, LAT_FDIV, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    drive(1'b1, 40, 1'b1, 0, 1'b0, 41, 1'b1, LAT_ALU, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_prestall got=%b exp=1", stall); end
    reset = 1'b0;
    model_reset();
    #1;
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL mid_rst_pending got=%b exp=0", pending_any); end
    checks++; if (stall !== 1'b0 || issue_fire !== 1'b0) begin errors++; $display("FAIL mid_rst_outs got=%b%b exp=00", stall, issue_fire); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_post_stall got=%b exp=0", stall); end
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL mid_post_fire got=%b exp=1", issue_fire); end
    tick();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 0, 1'b0, 1'b0);
    #1;
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL lat0_fire got=%b exp=1", issue_fire); end
    tick();
    checks++; if (lat_err !== 1'b1) begin errors++; $display("FAIL lat0_err got=%b exp=1", lat_err); end
    drive(1'b1, 9, 1'b1, 0, 1'b0, 10, 1'b1, LAT_ALU, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b0 || issue_fire !== 1'b1) begin errors++; $display("FAIL lat0_as_alu got=%b%b exp=01", stall, issue_fire); end
    tick();
    idle();
    repeat (3) tick();
    checks++; if (lat_err !== 1'b1) begin errors++; $display("FAIL lat_err_sticky got=%b exp=1", lat_err); end
  endtask

  task automatic test_random();
    bit es, ef;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 7,
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7),
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 7),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      #1;
      es = m_stall();
      ef = m_fire();
      checks++; if (stall !== es) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, stall, es); end
      checks++; if (issue_fire !== ef) begin errors++; $display("FAIL rnd_fire cyc=%0d got=%b exp=%b", c, issue_fire, ef); end
      tick();
      checks++; if (pending_any !== m_pending()) begin errors++; $display("FAIL rnd_pending cyc=%0d got=%b exp=%b", c, pending_any, m_pending()); end
      checks++; if (lat_err !== lat_err_m) begin errors++; $display("FAIL rnd_laterr cyc=%0d got=%b exp=%b", c, lat_err, lat_err_m); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_hazard_stalls();
    test_hold();
    test_reset_mid_and_lat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
